// File: rtl/uart_frac_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_frac_baud_gen
//
// Oversampling baud-tick generator for the UART. It divides clk by
// (baud_val+1), with an optional fractional stretch. It emits a one-clk
// baud_tick at OSR x baud. It also emits an xmit_tick once every OSR baud
// ticks. New divisors are double-buffered: a load is captured into the pending
// registers and becomes active only at a reload edge, so a rate change never
// produces a runt period.
//
// Build option:
//   UART_BAUD_FRAC_EN  defined   -> fractional accumulator and stretch are
//                                   built. Mean period is
//                                   active_val + 1 + active_frac / 2^FRAC_W.
//                      undefined -> baud_frac is ignored and the period is
//                                   exactly active_val + 1 clk.
//
// Parameters:
//   CNT_W   integer divisor width (2..24)
//   FRAC_W  fractional divisor width (1..8)
//   OSR     oversampling ratio, power of two (4..32)
//
// Ports:
//   clk        in   system clock
//   reset_n    in   synchronous active-low reset
//   enable     in   1 = run the divider, 0 = hold idle
//   baud_val   in   integer divisor, period = baud_val+1 clk
//   baud_frac  in   fractional divisor, units of 1/2^FRAC_W clk
//   load       in   one-cycle pulse that captures baud_val/baud_frac
//   load_ack   out  one-cycle pulse after the pending values became active
//   baud_tick  out  OSR x baud strobe
//   xmit_tick  out  1 x baud strobe, on every OSR-th baud_tick
//   osr_phase  out  tick index within the current bit, 0..OSR-1
// ---------------------------------------------------------------------------
module uart_frac_baud_gen #(
   parameter int CNT_W  = 16,
   parameter int FRAC_W = 4,
   parameter int OSR    = 16,
   localparam int OSR_W = $clog2(OSR)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic [CNT_W-1:0]  baud_val,
   input  logic [FRAC_W-1:0] baud_frac,
   input  logic              load,
   output logic              load_ack,
   output logic              baud_tick,
   output logic              xmit_tick,
   output logic [OSR_W-1:0]  osr_phase
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] active_val;
   logic [CNT_W-1:0] pend_val;
   logic             pend_flag;
   logic             at_reload;
   logic             transfer;

`ifdef UART_BAUD_FRAC_EN
   logic [FRAC_W-1:0] acc;
   logic [FRAC_W-1:0] active_frac;
   logic [FRAC_W-1:0] pend_frac;
   logic              stretch;
   logic [FRAC_W:0]   acc_sum;

   assign acc_sum   = {1'b0, acc} + {1'b0, active_frac};
   // A pending stretch holds cnt at zero for one extra clk before reloading.
   assign at_reload = (cnt == '0) && !stretch;
`else
   logic unused_frac;

   assign unused_frac = ^baud_frac;
   assign at_reload   = (cnt == '0);
`endif

   // Pending values move to active at a reload edge while running.
   // While idle, they move on the very next clk.
   assign transfer = pend_flag && (!enable || at_reload);

   // osr_phase holds the index of the tick currently visible.
   // This makes the last tick of a bit read OSR-1.
   assign xmit_tick = baud_tick && (osr_phase == OSR_W'(OSR - 1));

   // Down-counter, tick strobe and oversampling phase.
   // The reload edge that performs a transfer already counts with the new value.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt       <= '0;
         baud_tick <= 1'b0;
         osr_phase <= '0;
      end else if (!enable) begin
         cnt       <= '0;
         baud_tick <= 1'b0;
         osr_phase <= '0;
      end else begin
         baud_tick <= at_reload;
         if (baud_tick)
            osr_phase <= osr_phase + 1'b1;
         if (at_reload)
            cnt <= transfer ? pend_val : active_val;
         else if (cnt != '0)
            cnt <= cnt - 1'b1;
      end
   end

   // Integer divisor double buffer and load handshake.
   // A load on the transfer edge refills pending and keeps the flag set.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         active_val <= '0;
         pend_val   <= '0;
         pend_flag  <= 1'b0;
         load_ack   <= 1'b0;
      end else begin
         load_ack <= transfer;
         if (transfer)
            active_val <= pend_val;
         if (load) begin
            pend_val  <= baud_val;
            pend_flag <= 1'b1;
         end else if (transfer) begin
            pend_flag <= 1'b0;
         end
      end
   end

`ifdef UART_BAUD_FRAC_EN
   // Fractional divisor double buffer. It shares the handshake of the integer path.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         active_frac <= '0;
         pend_frac   <= '0;
      end else begin
         if (transfer)
            active_frac <= pend_frac;
         if (load)
            pend_frac <= baud_frac;
      end
   end

   // Fraction accumulator.
   // A carry out of the add stretches the following period by one clk.
   // A divisor change restarts the accumulator from zero with the new fraction.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         acc     <= '0;
         stretch <= 1'b0;
      end else if (!enable) begin
         acc     <= '0;
         stretch <= 1'b0;
      end else if (at_reload) begin
         if (transfer)
            {stretch, acc} <= {1'b0, pend_frac};
         else
            {stretch, acc} <= acc_sum;
      end else if (stretch && (cnt == '0)) begin
         stretch <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_uart_frac_baud_gen.sv
// ---------------------------------------------------------------------------
// tb_uart_frac_baud_gen
//
// Directed bench for uart_frac_baud_gen with CNT_W=16, FRAC_W=4 and OSR=16.
// Inputs change 1 ns after the rising edge. Outputs are sampled at the same
// point, so they show the register state produced by that edge.
// ---------------------------------------------------------------------------
module tb_uart_frac_baud_gen;

   localparam int CNT_W  = 16;
   localparam int FRAC_W = 4;
   localparam int OSR    = 16;
   localparam int OSR_W  = $clog2(OSR);

   logic              clk;
   logic              reset_n;
   logic              enable;
   logic [CNT_W-1:0]  baud_val;
   logic [FRAC_W-1:0] baud_frac;
   logic              load;
   logic              load_ack;
   logic              baud_tick;
   logic              xmit_tick;
   logic [OSR_W-1:0]  osr_phase;

   int checkCount;
   int failCount;

   uart_frac_baud_gen #(
      .CNT_W (CNT_W),
      .FRAC_W(FRAC_W),
      .OSR   (OSR)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .enable   (enable),
      .baud_val (baud_val),
      .baud_frac(baud_frac),
      .load     (load),
      .load_ack (load_ack),
      .baud_tick(baud_tick),
      .xmit_tick(xmit_tick),
      .osr_phase(osr_phase)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stop the run if something stalls far beyond the expected length.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input int actual, input int expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic ld,
                                input int val, input int frac);
      enable    = en;
      load      = ld;
      baud_val  = CNT_W'(val);
      baud_frac = FRAC_W'(frac);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic eventSeen(input int which);
      case (which)
         0:       return baud_tick;
         1:       return xmit_tick;
         default: return load_ack;
      endcase
   endfunction

   // Steps until the selected strobe is seen.
   // Returns the number of clks taken, or -1 if the limit is reached first.
   task automatic waitEvent(input int which, input int limit, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!eventSeen(which) && n < limit);
      if (!eventSeen(which))
         n = -1;
   endtask

   int n;
   int span;
   int cntSeen;

   initial begin
      checkCount = 0;
      failCount  = 0;
      reset_n    = 1'b0;
      applyStimulus(1'b0, 1'b0, 0, 0);
      step();
      step();

      // Reset state
      checkOutput("rst_baud_tick", int'(baud_tick), 0);
      checkOutput("rst_xmit_tick", int'(xmit_tick), 0);
      checkOutput("rst_load_ack",  int'(load_ack),  0);
      checkOutput("rst_osr_phase", int'(osr_phase), 0);
      reset_n = 1'b1;
      step();

      // Load while idle: the transfer happens on the next clk
      applyStimulus(1'b0, 1'b1, 3, 0);
      step();
      applyStimulus(1'b0, 1'b0, 3, 0);
      checkOutput("idle_ack_not_yet", int'(load_ack), 0);
      step();
      checkOutput("idle_ack", int'(load_ack), 1);
      step();
      checkOutput("idle_ack_single", int'(load_ack), 0);

      // Divider of 4 clk: a bit is 16 ticks and xmit_tick comes every 64 clk
      applyStimulus(1'b1, 1'b0, 3, 0);
      step();
      checkOutput("en_first_tick", int'(baud_tick), 1);
      checkOutput("en_first_phase", int'(osr_phase), 0);
      for (int i = 1; i < OSR; i++) begin
         waitEvent(0, 20, n);
         checkOutput($sformatf("p4_period_%0d", i), n, 4);
         checkOutput($sformatf("p4_phase_%0d", i), int'(osr_phase), i);
      end
      checkOutput("p4_xmit", int'(xmit_tick), 1);
      waitEvent(1, 200, n);
      checkOutput("p4_xmit_span", n, 64);
      checkOutput("p4_xmit_phase", int'(osr_phase), 15);

      // Half-clk fraction: periods are 4,5,4,5... when the feature is built
      applyStimulus(1'b1, 1'b1, 3, 8);
      step();
      applyStimulus(1'b1, 1'b0, 3, 8);
      waitEvent(2, 20, n);
      checkOutput("frac_ack_seen", int'(n > 0), 1);
      checkOutput("frac_ack_with_tick", int'(baud_tick), 1);
      span = 0;
      for (int i = 0; i < 16; i++) begin
         waitEvent(0, 20, n);
         span += n;
      end
`ifdef UART_BAUD_FRAC_EN
      checkOutput("frac_16_span", span, 72);
`else
      checkOutput("frac_16_span", span, 64);
`endif

      // Switch to a divisor of 10 and wait for it to take effect
      applyStimulus(1'b1, 1'b1, 9, 0);
      step();
      applyStimulus(1'b1, 1'b0, 9, 0);
      waitEvent(2, 20, n);
      checkOutput("p10_ack_seen", int'(n > 0), 1);

      // Load 4 while cnt is 5: the period of 10 finishes, then the period becomes 5
      for (int i = 0; i < 4; i++)
         step();
      applyStimulus(1'b1, 1'b1, 4, 0);
      step();
      applyStimulus(1'b1, 1'b0, 4, 0);
      waitEvent(0, 20, n);
      checkOutput("mid_load_rest", n, 5);
      checkOutput("mid_load_ack", int'(load_ack), 1);
      waitEvent(0, 20, n);
      checkOutput("mid_load_p5a", n, 5);
      waitEvent(0, 20, n);
      checkOutput("mid_load_p5b", n, 5);

      // Two loads in one period (7, then 2) give a single ack and a divisor of 3
      applyStimulus(1'b1, 1'b1, 7, 0);
      step();
      applyStimulus(1'b1, 1'b1, 2, 0);
      step();
      applyStimulus(1'b1, 1'b0, 2, 0);
      waitEvent(0, 20, n);
      checkOutput("dbl_load_rest", n, 3);
      checkOutput("dbl_load_ack", int'(load_ack), 1);
      cntSeen = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         cntSeen += int'(load_ack);
      end
      checkOutput("dbl_load_extra_acks", cntSeen, 0);
      checkOutput("dbl_load_p3", int'(baud_tick), 1);

      // Disable mid-period, then re-enable
      step();
      applyStimulus(1'b0, 1'b0, 2, 0);
      step();
      checkOutput("dis_tick", int'(baud_tick), 0);
      checkOutput("dis_phase", int'(osr_phase), 0);
      step();
      step();
      checkOutput("dis_tick_held", int'(baud_tick), 0);
      applyStimulus(1'b1, 1'b0, 2, 0);
      step();
      checkOutput("reen_tick", int'(baud_tick), 1);
      checkOutput("reen_phase", int'(osr_phase), 0);
      waitEvent(0, 20, n);
      checkOutput("reen_period", n, 3);

      // Reset while cnt is 6 and a load is pending: no ack, and active_val returns to 0
      applyStimulus(1'b1, 1'b1, 9, 0);
      step();
      applyStimulus(1'b1, 1'b0, 9, 0);
      waitEvent(2, 20, n);
      checkOutput("rst_setup_ack", int'(n > 0), 1);
      step();
      applyStimulus(1'b1, 1'b1, 5, 0);
      step();
      applyStimulus(1'b1, 1'b0, 5, 0);
      step();
      reset_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 5, 0);
      step();
      reset_n = 1'b1;
      checkOutput("midrst_tick", int'(baud_tick), 0);
      checkOutput("midrst_xmit", int'(xmit_tick), 0);
      checkOutput("midrst_ack",  int'(load_ack),  0);
      checkOutput("midrst_phase", int'(osr_phase), 0);
      cntSeen = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         cntSeen += int'(load_ack) + int'(baud_tick);
      end
      checkOutput("midrst_idle_quiet", cntSeen, 0);
      applyStimulus(1'b1, 1'b0, 5, 0);
      step();
      checkOutput("zero_div_tick1", int'(baud_tick), 1);
      step();
      checkOutput("zero_div_tick2", int'(baud_tick), 1);
      waitEvent(0, 5, n);
      checkOutput("zero_div_period", n, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
